// File: rtl/ili9341_pkg.sv
// Shared constants and FSM state encoding for the ILI9341 bus receiver.
package ili9341_pkg;

  localparam int DEF_WIDTH  = 240;
  localparam int DEF_HEIGHT = 320;

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_PASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;

  typedef enum logic [2:0] {
    IDLE,
    CASET,
    PASET,
    RAMWR,
    SKIP
  } rx_state_t;

endpackage

// File: rtl/ili9341_bus_sync.sv
// Bus input synchronisers plus write-strobe rising-edge detect gated by chip select.
module ili9341_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ncs,
  input  logic       cmd_data,
  input  logic       write_edge,
  input  logic       nreset,
  input  logic [7:0] din,
  output logic       strobe,
  output logic [7:0] data,
  output logic       dc,
  output logic       nreset_s
);

  // Bus bundle layout: {nreset, ncs, cmd_data, write_edge, din[7:0]}.
  // Rest value is an idle, deselected bus with the panel out of reset.
  localparam logic [11:0] BUS_REST = {1'b1, 1'b1, 1'b0, 1'b0, 8'h00};

  logic [SYNC_STAGES-1:0][11:0] sync_q;
  logic [11:0]                  bus_s;
  logic                         we_prev;

  // Shift every bus line through the synchroniser chain; remember the last strobe level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= {SYNC_STAGES{BUS_REST}};
      we_prev <= 1'b0;
    end else begin
      sync_q[0] <= {nreset, ncs, cmd_data, write_edge, din};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      we_prev <= sync_q[SYNC_STAGES-1][8];
    end
  end

  assign bus_s    = sync_q[SYNC_STAGES-1];
  // Edge tracking runs regardless of ncs, so a strobe rising while deselected is simply lost.
  assign strobe   = bus_s[8] & ~we_prev & ~bus_s[10];
  assign dc       = bus_s[9];
  assign data     = bus_s[7:0];
  assign nreset_s = bus_s[11];

endmodule

// File: rtl/ili9341_bus_receiver.sv
// ILI9341 8080 write-bus responder: command decode, window registers and RGB565 pixel stream.
module ili9341_bus_receiver
  import ili9341_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int HEIGHT      = DEF_HEIGHT,
  parameter int COORD_W     = 9,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ncs,
  input  logic               cmd_data,
  input  logic               write_edge,
  input  logic               nreset,
  input  logic [7:0]         din,
  output logic               pix_valid,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic [15:0]        pix_data,
  output logic               cmd_valid,
  output logic [7:0]         cmd_byte,
  output logic               frame_done
);

  localparam logic [15:0] W16 = 16'(WIDTH);
  localparam logic [15:0] H16 = 16'(HEIGHT);

  logic       strb, dc, nreset_s, swrst;
  logic [7:0] data;

  rx_state_t   state;
  logic [1:0]  param_idx;
  logic        byte_phase;
  logic [7:0]  hi;
  logic [23:0] shadow;
  logic [15:0] sc, ec, sp, ep;
  logic [15:0] cur_x, cur_y;
  logic        x_end, y_end;

  ili9341_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .reset      (reset),
    .ncs        (ncs),
    .cmd_data   (cmd_data),
    .write_edge (write_edge),
    .nreset     (nreset),
    .din        (din),
    .strobe     (strb),
    .data       (data),
    .dc         (dc),
    .nreset_s   (nreset_s)
  );

  assign swrst = strb & ~dc & (data == CMD_SWRESET);
  // >= rather than == so an inverted window degrades to a single row/column instead of running away.
  assign x_end = (cur_x >= ec);
  assign y_end = (cur_y >= ep);

  // Command/parameter FSM, window registers, pixel cursor and registered output pulses.
  always_ff @(posedge clk) begin
    if (reset || !nreset_s || swrst) begin
      // SWRESET shares the reset path but still reports itself as an accepted command.
      cmd_valid  <= swrst && !reset && nreset_s;
      cmd_byte   <= (swrst && !reset && nreset_s) ? CMD_SWRESET : 8'h00;
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_data   <= 16'h0000;
      state      <= IDLE;
      param_idx  <= 2'd0;
      byte_phase <= 1'b0;
      hi         <= 8'h00;
      shadow     <= 24'h0;
      sc         <= 16'h0000;
      ec         <= W16 - 16'd1;
      sp         <= 16'h0000;
      ep         <= H16 - 16'd1;
      cur_x      <= 16'h0000;
      cur_y      <= 16'h0000;
    end else begin
      pix_valid  <= 1'b0;
      cmd_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (strb && !dc) begin
        // Commands always win, dropping any partial parameter set or half pixel.
        cmd_valid  <= 1'b1;
        cmd_byte   <= data;
        param_idx  <= 2'd0;
        byte_phase <= 1'b0;
        case (data)
          CMD_CASET: state <= CASET;
          CMD_PASET: state <= PASET;
          CMD_RAMWR: begin
            state <= RAMWR;
            cur_x <= sc;
            cur_y <= sp;
          end
          default:   state <= SKIP;
        endcase
      end else if (strb) begin
        case (state)
          CASET, PASET: begin
            if (param_idx == 2'd3) begin
              // Window commits only once all four bytes have arrived.
              if (state == CASET) begin
                sc <= shadow[23:8];
                ec <= {shadow[7:0], data};
              end else begin
                sp <= shadow[23:8];
                ep <= {shadow[7:0], data};
              end
              param_idx <= 2'd0;
              state     <= SKIP;
            end else begin
              shadow    <= {shadow[15:0], data};
              param_idx <= param_idx + 2'd1;
            end
          end
          RAMWR: begin
            if (!byte_phase) begin
              hi         <= data;
              byte_phase <= 1'b1;
            end else begin
              byte_phase <= 1'b0;
              pix_data   <= {hi, data};
              pix_x      <= cur_x[COORD_W-1:0];
              pix_y      <= cur_y[COORD_W-1:0];
              // Off-panel pixels are dropped but still walk the cursor.
              pix_valid  <= (cur_x < W16) && (cur_y < H16);
              frame_done <= x_end && y_end;
              if (x_end) begin
                cur_x <= sc;
                cur_y <= y_end ? sp : cur_y + 16'd1;
              end else begin
                cur_x <= cur_x + 16'd1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
